// File: rtl/carwash_timer.sv
// Car wash spray/rinse timers: two independent prescaled countdown channels,
// each with an IDLE/RUN/EXPIRED FSM, level clear and sticky done flag.
module carwash_timer #(
   parameter int TICK_DIV = 1000,
   parameter int T1_TICKS = 30,
   parameter int T2_TICKS = 10
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        CLRT1,
   input  logic        CLRT2,
   output logic        T1DONE,
   output logic        T2DONE,
   output logic [15:0] T1REM,
   output logic [15:0] T2REM
);

   if ((TICK_DIV < 1) || (TICK_DIV > 65535) ||
       (T1_TICKS < 1) || (T1_TICKS > 65535) ||
       (T2_TICKS < 1) || (T2_TICKS > 65535)) begin : g_param_err
      $error("carwash_timer: TICK_DIV/T1_TICKS/T2_TICKS must be in 1..65535");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

   for (genvar g = 0; g < 2; g++) begin : g_ch
      localparam logic [15:0] TICKS = (g == 0) ? 16'(T1_TICKS) : 16'(T2_TICKS);

      logic        w_clr;
      state_t      r_state;
      logic [15:0] r_presc;
      logic [15:0] r_rem;
      logic        r_done;

      assign w_clr = (g == 0) ? CLRT1 : CLRT2;

      // Channel FSM; the IDLE->RUN edge leaves the prescaler at 0 so the
      // terminal tick lands exactly TICKS*TICK_DIV edges after it.
      always_ff @(posedge clk or negedge clr_n) begin
         if (!clr_n) begin
            r_state <= ST_IDLE;
            r_presc <= 16'd0;
            r_rem   <= TICKS;
            r_done  <= 1'b0;
         end else if (w_clr) begin
            r_state <= ST_IDLE;
            r_presc <= 16'd0;
            r_rem   <= TICKS;
            r_done  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_RUN;
                  r_presc <= 16'd0;
               end
               ST_RUN: begin
                  if (r_presc == DIV_LAST) begin
                     r_presc <= 16'd0;
                     if (r_rem <= 16'd1) begin
                        r_rem   <= 16'd0;
                        r_done  <= 1'b1;
                        r_state <= ST_EXPIRED;
                     end else begin
                        r_rem <= r_rem - 16'd1;
                     end
                  end else begin
                     r_presc <= r_presc + 16'd1;
                  end
               end
               ST_EXPIRED: begin
                  r_presc <= 16'd0;
                  r_rem   <= 16'd0;
                  r_done  <= 1'b1;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_presc <= 16'd0;
                  r_rem   <= TICKS;
                  r_done  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign T1DONE = g_ch[0].r_done;
   assign T1REM  = g_ch[0].r_rem;
   assign T2DONE = g_ch[1].r_done;
   assign T2REM  = g_ch[1].r_rem;

endmodule
